// File: rtl/core_pkg.sv
// Shared front-end definitions: opcodes, RS classes, sequencer states.
// Purely declarative (no logic, no latency).
// No flow control of its own; consumers apply their own handshakes.
package core_pkg;

    localparam int ROB_DEPTH_DEF = 16;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Reservation-station class and its one-hot {BR, LSU, ALU} request
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LSU = 2'd1,
        CLS_BR  = 2'd2
    } rs_class_t;

    localparam logic [2:0] RS_ALU_OH = 3'b001;
    localparam logic [2:0] RS_LSU_OH = 3'b010;
    localparam logic [2:0] RS_BR_OH  = 3'b100;

    typedef struct packed {
        rs_class_t cls;
        logic      fence;
        logic      illegal;
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_t;

    function automatic logic [2:0] class_onehot(input rs_class_t c);
        case (c)
            CLS_LSU: return RS_LSU_OH;
            CLS_BR:  return RS_BR_OH;
            default: return RS_ALU_OH;
        endcase
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps a major opcode to its RS class plus FENCE / illegal flags.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module opcode_classifier
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  info
);

    // Unknown opcodes go to the ALU slot flagged illegal so the ROB can raise the exception
    always_comb begin
        info = '{cls: CLS_ALU, fence: 1'b0, illegal: 1'b0};
        case (opcode)
            OPC_LOAD, OPC_STORE:           info.cls = CLS_LSU;
            OPC_BRANCH, OPC_JAL, OPC_JALR: info.cls = CLS_BR;
            OPC_LUI, OPC_AUIPC,
            OPC_OPIMM, OPC_OP:             info.cls = CLS_ALU;
            OPC_FENCE:                     info.fence = 1'b1;
            default:                       info.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/issue_sequencer.sv
// Pulls instructions from the queue, allocates a ROB tag and an RS slot, pulses the decoder.
// Latency: accept -> decode_pulse 2 clocks; best-case one issue every 2 cycles.
// Backpressure: iq_ready only in IDLE; stalls while ROB/RS full or a FENCE waits for an empty ROB.
module issue_sequencer
    import core_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iq_valid,
    input  logic [31:0]      iq_instr,
    output logic             iq_ready,
    input  logic [TAG_W:0]   rob_free,
    input  logic             rob_empty,
    input  logic             rs_alu_free,
    input  logic             rs_lsu_free,
    input  logic             rs_br_free,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    output logic [31:0]      decode_instr,
    output logic             decode_pulse,
    output logic             available,
    output logic             rob_alloc,
    output logic [TAG_W-1:0] rob_tag,
    output logic [2:0]       rs_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [31:0]      instr_q;
    op_class_t        cls_q;
    op_class_t        cls_in;
    logic [TAG_W-1:0] tail;
    logic             rs_ok;
    logic             ok;
    logic             accept;
    logic             issue;

    // Classify at capture time so CHECK only has to look at registered class bits
    opcode_classifier u_classifier (
        .opcode (iq_instr[6:0]),
        .info   (cls_in)
    );

    // Capacity of the RS the held instruction targets
    always_comb begin
        case (cls_q.cls)
            CLS_LSU: rs_ok = rs_lsu_free;
            CLS_BR:  rs_ok = rs_br_free;
            default: rs_ok = rs_alu_free;
        endcase
        ok = (rob_free != '0) && rs_ok && (!cls_q.fence || rob_empty);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic; flush overrides everything, including a ready issue
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:            if (iq_valid) next_state = ST_CHECK;
                ST_CHECK, ST_STALL: next_state = ok ? ST_IDLE : ST_STALL;
                default:            next_state = ST_IDLE;
            endcase
        end
    end

    // State decodes: queue handshake and the issue decision
    always_comb begin
        iq_ready = (state == ST_IDLE);
        accept   = iq_ready && iq_valid && !flush;
        issue    = ((state == ST_CHECK) || (state == ST_STALL)) && ok && !flush;
    end

    // Hold the accepted instruction and its class until it issues or is flushed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            cls_q   <= '0;
        end else if (accept) begin
            instr_q <= iq_instr;
            cls_q   <= cls_in;
        end
    end

    // ROB tail: restart point on flush, otherwise advance per issue (wraps at ROB_DEPTH)
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      tail <= '0;
        else if (flush) tail <= flush_tag;
        else if (issue) tail <= tail + TAG_W'(1);
    end

    // Registered issue outputs: single-cycle strobes, decode_instr holds the last issued word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decode_instr <= '0;
            decode_pulse <= 1'b0;
            available    <= 1'b0;
            rob_alloc    <= 1'b0;
            rob_tag      <= '0;
            rs_sel       <= '0;
            illegal      <= 1'b0;
        end else begin
            decode_pulse <= issue;
            available    <= issue;
            rob_alloc    <= issue;
            rob_tag      <= issue ? tail : '0;
            rs_sel       <= issue ? class_onehot(cls_q.cls) : 3'b000;
            illegal      <= issue && cls_q.illegal;
            if (issue) decode_instr <= instr_q;
        end
    end

    // Performance counters, free-running with silent wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue)             issue_count <= issue_count + CNT_ONE;
            if (state == ST_STALL) stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
// Model predicts each cycle's outputs from the held-instruction status and resource inputs.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the next edge.
module tb_issue_sequencer;

    localparam int RD = 16;

    logic        clock;
    logic        reset;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic        iq_ready;
    logic [4:0]  rob_free;
    logic        rob_empty;
    logic        rs_alu_free;
    logic        rs_lsu_free;
    logic        rs_br_free;
    logic        flush;
    logic [3:0]  flush_tag;
    logic [31:0] decode_instr;
    logic        decode_pulse;
    logic        available;
    logic        rob_alloc;
    logic [3:0]  rob_tag;
    logic [2:0]  rs_sel;
    logic        illegal;
    logic [31:0] issue_count;
    logic [31:0] stall_count;

    issue_sequencer #(.ROB_DEPTH(16), .TAG_W(4), .CNT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .iq_valid     (iq_valid),
        .iq_instr     (iq_instr),
        .iq_ready     (iq_ready),
        .rob_free     (rob_free),
        .rob_empty    (rob_empty),
        .rs_alu_free  (rs_alu_free),
        .rs_lsu_free  (rs_lsu_free),
        .rs_br_free   (rs_br_free),
        .flush        (flush),
        .flush_tag    (flush_tag),
        .decode_instr (decode_instr),
        .decode_pulse (decode_pulse),
        .available    (available),
        .rob_alloc    (rob_alloc),
        .rob_tag      (rob_tag),
        .rs_sel       (rs_sel),
        .illegal      (illegal),
        .issue_count  (issue_count),
        .stall_count  (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: is an instruction held, has it been examined yet, is a flush draining
    bit          m_busy;
    bit          m_first;
    bit          m_in_flush;
    logic [31:0] m_instr;
    logic [31:0] m_dec;
    int          m_tail;
    int          m_issues;
    int          m_stalls;

    task automatic model_reset();
        m_busy = 0; m_first = 0; m_in_flush = 0;
        m_instr = '0; m_dec = '0;
        m_tail = 0; m_issues = 0; m_stalls = 0;
    endtask

    // rs: one-hot {BR,LSU,ALU} request
    task automatic mclass(input logic [31:0] ins, output int rs, output bit fe, output bit il);
        logic [6:0] op;
        op = ins[6:0];
        rs = 1; fe = 0; il = 0;
        case (op)
            7'h03, 7'h23:        rs = 2;
            7'h63, 7'h6F, 7'h67: rs = 4;
            7'h37, 7'h17, 7'h13, 7'h33: rs = 1;
            7'h0F:               fe = 1;
            default:             il = 1;
        endcase
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input int rf, input bit re,
                         input bit a, input bit l, input bit b, input bit f, input int ft);
        iq_valid = v; iq_instr = ins; rob_free = 5'(rf); rob_empty = re;
        rs_alu_free = a; rs_lsu_free = l; rs_br_free = b; flush = f; flush_tag = 4'(ft);
    endtask

    // Advance one clock: predict from current inputs, clock the DUT, compare everything
    task automatic step();
        bit e_pulse; int e_tag; int e_rs; bit e_ill;
        int rs; bit fe; bit il; bit res_ok;
        e_pulse = 0; e_tag = 0; e_rs = 0; e_ill = 0;
        if (m_busy && !m_first) m_stalls++;
        if (flush) begin
            m_busy = 0; m_in_flush = 1; m_tail = int'(flush_tag);
        end else if (m_in_flush) begin
            m_in_flush = 0;
        end else if (!m_busy) begin
            if (iq_valid) begin m_busy = 1; m_first = 1; m_instr = iq_instr; end
        end else begin
            mclass(m_instr, rs, fe, il);
            res_ok = (rs == 1 && rs_alu_free) || (rs == 2 && rs_lsu_free) || (rs == 4 && rs_br_free);
            if (rob_free >= 1 && res_ok && (!fe || rob_empty)) begin
                e_pulse = 1; e_tag = m_tail; e_rs = rs; e_ill = il; m_dec = m_instr;
                m_tail = (m_tail + 1) % RD; m_issues++; m_busy = 0;
            end else begin
                m_first = 0;
            end
        end
        @(posedge clock); #1;
        chk("iq_ready", iq_ready, !m_busy && !m_in_flush);
        chk("decode_pulse", decode_pulse, e_pulse);
        chk("available", available, e_pulse);
        chk("rob_alloc", rob_alloc, e_pulse);
        chk("rob_tag", rob_tag, e_tag);
        chk("rs_sel", rs_sel, e_rs);
        chk("illegal", illegal, e_ill);
        chk("decode_instr", decode_instr, m_dec);
        chk("issue_count", issue_count, m_issues);
        chk("stall_count", stall_count, m_stalls);
    endtask

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] FENCE = 32'h0FF0000F;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] BADOP = 32'h0000007F;

    logic [6:0] opc_tab [12] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                 7'h17, 7'h13, 7'h33, 7'h0F, 7'h7F, 7'h00};

    initial begin
        model_reset();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_iq_ready", iq_ready, 1);
        chk("rst_pulse", decode_pulse, 0);
        chk("rst_rs_sel", rs_sel, 0);
        chk("rst_issue_count", issue_count, 0);

        // ADDI, everything free: ready drops, pulse 2 clocks after accept
        drive(1, ADDI, 16, 1, 1, 1, 1, 0, 0); step();
        chk("addi_ready_low", iq_ready, 0);
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0);   step();
        chk("addi_tag", rob_tag, 0);
        chk("addi_rs", rs_sel, 3'b001);
        chk("addi_cnt", issue_count, 1);

        // LW with LSU RS full for three cycles
        step();
        drive(1, LW, 16, 1, 1, 0, 1, 0, 0); step();
        drive(0, '0, 16, 1, 1, 0, 1, 0, 0);
        repeat (3) step();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        chk("lw_stalls", stall_count, 3);
        chk("lw_rs", rs_sel, 3'b010);
        chk("lw_tag", rob_tag, 1);
        step();

        // FENCE waits for an empty ROB
        drive(1, FENCE, 16, 0, 1, 1, 1, 0, 0); step();
        drive(0, '0, 16, 0, 1, 1, 1, 0, 0);
        repeat (5) step();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        chk("fence_rs", rs_sel, 3'b001);
        step();

        // Restart tail at 0, then 17 back-to-back BEQs exercise the wrap
        drive(0, '0, 16, 1, 1, 1, 1, 1, 0); step();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        for (int i = 0; i < 17; i++) begin
            drive(1, BEQ, 16, 1, 1, 1, 1, 0, 0); step();
            step();
            chk("beq_tag", rob_tag, i % RD);
            chk("beq_rs", rs_sel, 3'b100);
        end

        // ROB full stalls even with every RS free
        drive(1, ADDI, 0, 1, 1, 1, 1, 0, 0); step();
        drive(0, '0, 0, 1, 1, 1, 1, 0, 0); repeat (3) step();
        chk("robfull_no_alloc", rob_alloc, 0);

        // Flush while stalled: drop the instruction, restart at tag 9
        drive(0, '0, 16, 1, 1, 1, 1, 1, 9); step();
        chk("flush_no_pulse", decode_pulse, 0);
        chk("flush_ready_low", iq_ready, 0);
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        chk("flush_back_idle", iq_ready, 1);
        drive(1, ADDI, 16, 1, 1, 1, 1, 0, 0); step();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        chk("flush_tag9", rob_tag, 9);

        // Unrecognised opcode
        drive(1, BADOP, 16, 1, 1, 1, 1, 0, 0); step();
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0); step();
        chk("illegal_flag", illegal, 1);
        chk("illegal_rs", rs_sel, 3'b001);

        // Asynchronous reset while in CHECK
        drive(1, ADDI, 16, 1, 1, 1, 1, 0, 0); step();
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", iq_ready, 1);
        chk("arst_pulse", decode_pulse, 0);
        chk("arst_issue_count", issue_count, 0);
        chk("arst_stall_count", stall_count, 0);
        chk("arst_instr", decode_instr, 0);
        drive(0, '0, 16, 1, 1, 1, 1, 0, 0);
        @(posedge clock); #1 reset = 1'b0;
        model_reset();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r;
            int rf;
            r  = $urandom();
            rf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 16);
            drive($urandom_range(0, 9) < 7, {r[31:7], opc_tab[$urandom_range(0, 11)]}, rf,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
Front-end controller between the instruction queue and the instruction decoder / ROB / reservation stations of the out-of-order core.
- Pulls one instruction from the queue.
- Classifies it by opcode and checks ROB and target-RS capacity.
- Emits the decode pulse and the decoder's `available` qualifier.
- Allocates a ROB tag and a one-hot RS slot request.
- Stalls on full, serialises FENCE, and discards in-flight work on pipeline flush.

Parameters:
ROB_DEPTH, 16, number of ROB entries; tags wrap modulo ROB_DEPTH (power of two).
TAG_W, 4, ROB tag width = log2(ROB_DEPTH).
CNT_W, 32, width of the performance counters.

Ports:
clock  in  1  single core clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
iq_valid  in  1  instruction queue holds a valid instruction.
iq_instr  in  32  instruction word from the queue.
iq_ready  out  1  sequencer accepts `iq_instr` this cycle.
rob_free  in  TAG_W+1  number of free ROB entries, 0..ROB_DEPTH.
rob_empty  in  1  ROB holds no uncommitted entries.
rs_alu_free  in  1  ALU reservation station has ≥1 free slot.
rs_lsu_free  in  1  load/store reservation station has ≥1 free slot.
rs_br_free  in  1  branch reservation station has ≥1 free slot.
flush  in  1  mispredict or exception flush request.
flush_tag  in  TAG_W  ROB tail value to restart from after a flush.
decode_instr  out  32  registered instruction presented to the decoder.
decode_pulse  out  1  one-cycle strobe that triggers the decoder.
available  out  1  decoder qualifier; high whenever `decode_pulse` is high.
rob_alloc  out  1  allocate one ROB entry at `rob_tag`.
rob_tag  out  TAG_W  tag of the entry being allocated.
rs_sel  out  3  one-hot {BR, LSU, ALU} RS allocation; zero when not issuing.
illegal  out  1  issued opcode is unrecognised; the ROB marks the entry as an exception.
issue_count  out  CNT_W  total instructions issued.
stall_count  out  CNT_W  total cycles spent in STALL.

Behaviour:
- Reset values: state = IDLE; `tail` = 0; all outputs 0 except `iq_ready`, which is 1 in IDLE.
- All outputs are registered. `iq_ready` is a decode of the state register.
- States: IDLE, CHECK, STALL, FLUSH.
- IDLE:
  - `iq_ready` = 1.
  - When `iq_valid` is high, capture `iq_instr` into `instr_q`, compute class, and go to CHECK.
- Classification from `instr[6:0]`:
  - 0000011 / 0100011 → LSU.
  - 1100011 / 1101111 / 1100111 → BR.
  - 0110111 / 0010111 / 0010011 / 0110011 → ALU.
  - 0001111 → ALU with FENCE flag.
  - Any other opcode → ALU with `illegal` = 1.
- Issue condition (`ok`): `rob_free` ≥ 1, AND the target `rs_*_free` is high, AND (not FENCE, or `rob_empty` = 1).
- CHECK, STALL:
  - If `ok`, issue and go to IDLE. STALL re-evaluates every cycle.
  - If not `ok`: go to / stay in STALL, and `stall_count` += 1 per STALL cycle.
- Issue cycle (outputs valid for exactly one cycle):
  - `decode_pulse` = 1, `available` = 1, `decode_instr` = `instr_q`.
  - `rob_alloc` = 1, `rob_tag` = `tail`.
  - `rs_sel` = one-hot class.
  - `tail` = (`tail` + 1) mod ROB_DEPTH; `issue_count` += 1.
- Throughput: a best-case issue every 2 cycles. Latency from IDLE accept to `decode_pulse` = 2 clocks.
- `iq_ready` = 0 in CHECK, STALL and FLUSH.
- Flush (highest priority, any state):
  - Next state = FLUSH. The captured instruction is dropped and no issue occurs that cycle, even if `ok`.
  - `tail` = `flush_tag`.
  - FLUSH lasts one cycle, then goes to IDLE.
  - `flush` held high keeps the block in FLUSH.
- Wrap-around: `tail` = ROB_DEPTH-1 issues tag ROB_DEPTH-1, then `tail` becomes 0.
- `rob_free` = 0 with all RS free → STALL. Never allocate beyond capacity.
- Counters wrap silently at 2^CNT_W.
- Reset asserted mid-operation: immediate asynchronous return to the reset values. Pulses are cut off.

Decomposition:
- Shared package `core_pkg`:
  - Opcode constants (LUI, AUIPC, JAL, JALR, BRANCH = 7'b1100011, LOAD, STORE, OPIMM, OP, FENCE).
  - RS class encoding / one-hot constants.
  - State enum.
  - ROB_DEPTH default.
- One sub-module is natural: `opcode_classifier`, combinational opcode → {class, fence, illegal}. It is reused later by the dispatch unit.

Test Plan:
- Reset, then ADDI 0x00500093 valid with all resources free → `iq_ready` low next cycle; 2 clocks after accept: `decode_pulse` = 1, `rob_tag` = 0, `rs_sel` = 001; `issue_count` = 1.
- LW 0x0000A103 with `rs_lsu_free` = 0 for 3 cycles, then 1 → `stall_count` = 3; a single issue with `rs_sel` = 010, `rob_tag` = 1.
- FENCE 0x0FF0000F with `rob_empty` = 0 for 5 cycles → no pulse; `rob_empty` = 1 → issue with `rs_sel` = 001.
- 16 back-to-back BEQ 0x00208463 → `rob_tag` sequence 0..15, then the 17th issue gets `rob_tag` = 0; `rs_sel` = 100 on each.
- `flush` asserted in STALL with `flush_tag` = 9 → no issue, one FLUSH cycle, IDLE; next issued instruction has `rob_tag` = 9.
- Opcode 0x0000007F → issue with `illegal` = 1 and `rs_sel` = 001. Asserting `reset` during CHECK clears all outputs within the same cycle.
